// File: rtl/boot_run_ctrl_if.sv
// Loader stream and imem write port bundle for boot_run_ctrl.
// slave = sequencer side, master = host/loader side.
interface boot_run_ctrl_if #(
   parameter int AW = 10
);
   logic          in_valid;
   logic [31:0]   in_data;
   logic          in_ready;
   logic          imem_we;
   logic [AW-1:0] imem_waddr;
   logic [31:0]   imem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, imem_we, imem_waddr, imem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, imem_we, imem_waddr, imem_wdata
   );
endinterface

// File: rtl/boot_run_ctrl.sv
// Boot/run sequencer: loads a program image into imem,
// releases core reset after a delay, counts run cycles.
module boot_run_ctrl #(
   parameter int IMEM_DEPTH      = 1024,
   parameter int IMEM_ADDR_WIDTH = 10,
   parameter int RELEASE_DLY     = 2,
   parameter int CNT_WIDTH       = 32,
   parameter int MAX_CYCLES      = 100000
) (
   input  logic                     clk,
   input  logic                     reset_b,
   input  logic                     start,
   input  logic                     abort,
   boot_run_ctrl_if.slave           bus,
   output logic                     core_rst_b,
   input  logic                     halt_req,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout,
   output logic                     error,
   output logic [CNT_WIDTH-1:0]     cycle_cnt,
   output logic [IMEM_ADDR_WIDTH:0] load_cnt
);
   localparam int LW = IMEM_ADDR_WIDTH + 1;
   localparam logic [31:0] DEPTH32 = 32'(IMEM_DEPTH);
   localparam logic [CNT_WIDTH-1:0] LAST_CYC = CNT_WIDTH'(MAX_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_SAT = '1;
   localparam logic [3:0] DLY = 4'(RELEASE_DLY);

   typedef enum logic [2:0] {
      IDLE, HDR, LOAD, RELEASE, RUN, DONE, ERR
   } state_t;

   state_t        state;
   logic [LW-1:0] n_words;
   logic [3:0]    dly_cnt;
   logic          accept;

   // stream is open only while expecting header or program words
   assign bus.in_ready = (state == HDR) || (state == LOAD);
   assign accept       = bus.in_valid & bus.in_ready;

   // sequencer FSM with registered outputs; abort overrides everything
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state          <= IDLE;
         n_words        <= '0;
         dly_cnt        <= '0;
         bus.imem_we    <= 1'b0;
         bus.imem_waddr <= '0;
         bus.imem_wdata <= '0;
         core_rst_b     <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         timeout        <= 1'b0;
         error          <= 1'b0;
         cycle_cnt      <= '0;
         load_cnt       <= '0;
      end else begin
         bus.imem_we <= 1'b0;
         if (abort) begin
            state      <= IDLE;
            core_rst_b <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            error      <= 1'b0;
         end else begin
            unique case (state)
               IDLE, DONE, ERR: begin
                  if (start) begin
                     state     <= HDR;
                     busy      <= 1'b1;
                     done      <= 1'b0;
                     timeout   <= 1'b0;
                     error     <= 1'b0;
                     load_cnt  <= '0;
                     cycle_cnt <= '0;
                  end
               end
               HDR: begin
                  if (accept) begin
                     if (bus.in_data == '0 || bus.in_data > DEPTH32) begin
                        state <= ERR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                     end else begin
                        n_words <= bus.in_data[LW-1:0];
                        state   <= LOAD;
                     end
                  end
               end
               LOAD: begin
                  if (accept) begin
                     bus.imem_we    <= 1'b1;
                     bus.imem_waddr <= load_cnt[IMEM_ADDR_WIDTH-1:0];
                     bus.imem_wdata <= bus.in_data;
                     load_cnt       <= load_cnt + 1'b1;
                     if (load_cnt + 1'b1 == n_words) begin
                        state   <= RELEASE;
                        dly_cnt <= DLY;
                     end
                  end
               end
               RELEASE: begin
                  if (dly_cnt <= 4'd1) begin
                     state      <= RUN;
                     core_rst_b <= 1'b1;
                  end else begin
                     dly_cnt <= dly_cnt - 1'b1;
                  end
               end
               RUN: begin
                  if (cycle_cnt != CNT_SAT)
                     cycle_cnt <= cycle_cnt + 1'b1;
                  if (halt_req) begin
                     state      <= DONE;
                     done       <= 1'b1;
                     core_rst_b <= 1'b0;
                     busy       <= 1'b0;
                  end else if (MAX_CYCLES != 0 && cycle_cnt == LAST_CYC) begin
                     state      <= DONE;
                     done       <= 1'b1;
                     timeout    <= 1'b1;
                     core_rst_b <= 1'b0;
                     busy       <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_boot_run_ctrl.sv
// Directed bench for boot_run_ctrl.
// Run limit shortened to 10 cycles.
module tb_boot_run_ctrl;
   localparam int AW = 10;

   logic clk = 1'b0;
   logic reset_b = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic halt_req = 1'b0;
   logic core_rst_b, busy, done, timeout, error;
   logic [31:0] cycle_cnt;
   logic [AW:0] load_cnt;

   boot_run_ctrl_if #(.AW(AW)) b ();

   boot_run_ctrl #(.MAX_CYCLES(10)) dut (
      .clk(clk), .reset_b(reset_b), .start(start), .abort(abort),
      .bus(b.slave), .core_rst_b(core_rst_b), .halt_req(halt_req),
      .busy(busy), .done(done), .timeout(timeout), .error(error),
      .cycle_cnt(cycle_cnt), .load_cnt(load_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   logic [AW-1:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int wr_cyc[$];
   int acc_cyc[$];
   logic [31:0] prog[8] = '{32'h00500093, 32'h00100113, 32'h002081b3,
      32'h00000013, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (b.imem_we === 1'b1) begin
         wr_addr.push_back(b.imem_waddr);
         wr_data.push_back(b.imem_wdata);
         wr_cyc.push_back(cyc);
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      int k;
      b.in_valid = 1'b0;
      repeat (gap) step();
      b.in_valid = 1'b1;
      b.in_data = w;
      k = 0;
      while (b.in_ready !== 1'b1 && k < 50) begin
         step();
         k++;
      end
      if (k >= 50) begin
         $display("FAIL accept_wait: in_ready=%b required 1", b.in_ready);
         n_cmp++;
         n_bad++;
      end else begin
         step();
         acc_cyc.push_back(cyc);
      end
      b.in_valid = 1'b0;
   endtask

   task automatic load_prog(input int n, input bit gaps);
      pulse_start();
      send_word(32'(n), 0);
      for (int i = 0; i < n; i++)
         send_word(prog[i], gaps ? int'($urandom_range(0, 1)) : 0);
   endtask

   task automatic test_reset();
      step();
      step();
      n_cmp++;
      if ({b.in_ready, b.imem_we, core_rst_b, busy, done, timeout, error} !== 7'b0) begin
         $display("FAIL reset_flags: got %b required 0000000",
            {b.in_ready, b.imem_we, core_rst_b, busy, done, timeout, error});
         n_bad++;
      end
      n_cmp++;
      if (b.imem_waddr !== '0 || b.imem_wdata !== 32'h0) begin
         $display("FAIL reset_wport: got %h/%h required 0/0", b.imem_waddr, b.imem_wdata);
         n_bad++;
      end
      n_cmp++;
      if (cycle_cnt !== 32'd0 || load_cnt !== 11'd0) begin
         $display("FAIL reset_cnt: got %0d/%0d required 0/0", cycle_cnt, load_cnt);
         n_bad++;
      end
      reset_b = 1'b1;
      step();
   endtask

   task automatic test_load();
      int w0;
      w0 = wr_addr.size();
      load_prog(4, 0);
      n_cmp++;
      if (b.imem_we !== 1'b1 || core_rst_b !== 1'b0) begin
         $display("FAIL load_last_cycle: we=%b rst_b=%b required 1/0", b.imem_we, core_rst_b);
         n_bad++;
      end
      step();
      n_cmp++;
      if (core_rst_b !== 1'b0) begin
         $display("FAIL load_rel_hold: rst_b=%b required 0", core_rst_b);
         n_bad++;
      end
      step();
      n_cmp++;
      if (core_rst_b !== 1'b1 || busy !== 1'b1) begin
         $display("FAIL load_release: rst_b=%b busy=%b required 1/1", core_rst_b, busy);
         n_bad++;
      end
      n_cmp++;
      if (load_cnt !== 11'd4) begin
         $display("FAIL load_cnt: got %0d required 4", load_cnt);
         n_bad++;
      end
      n_cmp++;
      if (wr_addr.size() - w0 != 4) begin
         $display("FAIL load_nwr: got %0d required 4", wr_addr.size() - w0);
         n_bad++;
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (wr_addr[w0+i] !== AW'(i) || wr_data[w0+i] !== prog[i]
                || (i > 0 && wr_cyc[w0+i] != wr_cyc[w0+i-1] + 1)) begin
               $display("FAIL load_wr%0d: got %0d:%h required %0d:%h consecutive",
                  i, wr_addr[w0+i], wr_data[w0+i], i, prog[i]);
               n_bad++;
            end
         end
      end
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
   endtask

   task automatic test_gaps();
      int w0;
      int a0;
      w0 = wr_addr.size();
      a0 = acc_cyc.size();
      load_prog(8, 1);
      n_cmp++;
      if (b.in_ready !== 1'b0) begin
         $display("FAIL gap_ready_rel: got %b required 0", b.in_ready);
         n_bad++;
      end
      step();
      step();
      n_cmp++;
      if (wr_addr.size() - w0 != 8 || acc_cyc.size() - a0 != 9) begin
         $display("FAIL gap_nwr: got %0d writes required 8", wr_addr.size() - w0);
         n_bad++;
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (wr_addr[w0+i] !== AW'(i) || wr_data[w0+i] !== prog[i]
                || wr_cyc[w0+i] != acc_cyc[a0+1+i]) begin
               $display("FAIL gap_wr%0d: got %0d:%h@%0d required %0d:%h@%0d", i,
                  wr_addr[w0+i], wr_data[w0+i], wr_cyc[w0+i], i, prog[i], acc_cyc[a0+1+i]);
               n_bad++;
            end
         end
      end
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      n_cmp++;
      if (b.in_ready !== 1'b0 || done !== 1'b1) begin
         $display("FAIL gap_done: ready=%b done=%b required 0/1", b.in_ready, done);
         n_bad++;
      end
   endtask

   task automatic test_bad_hdr();
      int w0;
      w0 = wr_addr.size();
      pulse_start();
      send_word(32'd0, 0);
      n_cmp++;
      if ({error, busy, core_rst_b, b.in_ready} !== 4'b1000) begin
         $display("FAIL hdr0: err/busy/rst_b/ready=%b required 1000",
            {error, busy, core_rst_b, b.in_ready});
         n_bad++;
      end
      pulse_start();
      n_cmp++;
      if (error !== 1'b0 || b.in_ready !== 1'b1) begin
         $display("FAIL hdr_restart: err=%b ready=%b required 0/1", error, b.in_ready);
         n_bad++;
      end
      send_word(32'd1025, 0);
      step();
      n_cmp++;
      if (error !== 1'b1 || core_rst_b !== 1'b0 || wr_addr.size() != w0) begin
         $display("FAIL hdr1025: err=%b rst_b=%b writes=%0d required 1/0/0",
            error, core_rst_b, wr_addr.size() - w0);
         n_bad++;
      end
      load_prog(3, 0);
      step();
      step();
      n_cmp++;
      if (error !== 1'b0 || core_rst_b !== 1'b1 || wr_addr.size() - w0 != 3) begin
         $display("FAIL hdr_recover: err=%b rst_b=%b writes=%0d required 0/1/3",
            error, core_rst_b, wr_addr.size() - w0);
         n_bad++;
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic test_timeout();
      load_prog(2, 0);
      step();
      step();
      repeat (9) step();
      n_cmp++;
      if (done !== 1'b0 || cycle_cnt !== 32'd9 || core_rst_b !== 1'b1) begin
         $display("FAIL to_pre: done=%b cnt=%0d rst_b=%b required 0/9/1",
            done, cycle_cnt, core_rst_b);
         n_bad++;
      end
      step();
      n_cmp++;
      if ({done, timeout, core_rst_b, busy} !== 4'b1100 || cycle_cnt !== 32'd10) begin
         $display("FAIL to_done: done/to/rst_b/busy=%b cnt=%0d required 1100/10",
            {done, timeout, core_rst_b, busy}, cycle_cnt);
         n_bad++;
      end
      step();
      n_cmp++;
      if (done !== 1'b1 || cycle_cnt !== 32'd10) begin
         $display("FAIL to_hold: done=%b cnt=%0d required 1/10", done, cycle_cnt);
         n_bad++;
      end
   endtask

   task automatic test_halt_last();
      load_prog(2, 0);
      step();
      step();
      repeat (9) step();
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      n_cmp++;
      if (done !== 1'b1 || timeout !== 1'b0 || cycle_cnt !== 32'd10) begin
         $display("FAIL halt_last: done=%b to=%b cnt=%0d required 1/0/10",
            done, timeout, cycle_cnt);
         n_bad++;
      end
   endtask

   task automatic test_halt_first();
      load_prog(1, 0);
      step();
      step();
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      n_cmp++;
      if (done !== 1'b1 || cycle_cnt !== 32'd1 || core_rst_b !== 1'b0) begin
         $display("FAIL halt_first: done=%b cnt=%0d rst_b=%b required 1/1/0",
            done, cycle_cnt, core_rst_b);
         n_bad++;
      end
   endtask

   task automatic test_abort();
      int w0;
      w0 = wr_addr.size();
      pulse_start();
      send_word(32'd4, 0);
      send_word(prog[0], 0);
      send_word(prog[1], 0);
      abort = 1'b1;
      b.in_valid = 1'b1;
      b.in_data = prog[2];
      step();
      abort = 1'b0;
      b.in_valid = 1'b0;
      n_cmp++;
      if ({busy, b.in_ready, core_rst_b, b.imem_we} !== 4'b0 || load_cnt !== 11'd2) begin
         $display("FAIL abort_load: busy/ready/rst_b/we=%b lcnt=%0d required 0000/2",
            {busy, b.in_ready, core_rst_b, b.imem_we}, load_cnt);
         n_bad++;
      end
      step();
      step();
      n_cmp++;
      if (wr_addr.size() - w0 != 2) begin
         $display("FAIL abort_writes: got %0d required 2", wr_addr.size() - w0);
         n_bad++;
      end
      load_prog(1, 0);
      step();
      step();
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || cycle_cnt !== 32'd2 || b.in_ready !== 1'b0) begin
         $display("FAIL start_ignored: busy=%b cnt=%0d ready=%b required 1/2/0",
            busy, cycle_cnt, b.in_ready);
         n_bad++;
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      n_cmp++;
      if ({busy, core_rst_b, done, b.in_ready} !== 4'b0 || cycle_cnt !== 32'd2) begin
         $display("FAIL abort_run: busy/rst_b/done/ready=%b cnt=%0d required 0000/2",
            {busy, core_rst_b, done, b.in_ready}, cycle_cnt);
         n_bad++;
      end
   endtask

   task automatic test_async_reset();
      load_prog(1, 0);
      step();
      step();
      step();
      #2 reset_b = 1'b0;
      #1;
      n_cmp++;
      if ({b.in_ready, b.imem_we, core_rst_b, busy, done, timeout, error} !== 7'b0
          || cycle_cnt !== 32'd0 || load_cnt !== 11'd0) begin
         $display("FAIL async_reset: flags=%b cnt=%0d lcnt=%0d required 0/0/0",
            {b.in_ready, b.imem_we, core_rst_b, busy, done, timeout, error},
            cycle_cnt, load_cnt);
         n_bad++;
      end
      step();
      reset_b = 1'b1;
      step();
   endtask

   initial begin
      b.in_valid = 1'b0;
      b.in_data = 32'h0;
      test_reset();
      test_load();
      test_gaps();
      test_bad_hdr();
      test_timeout();
      test_halt_last();
      test_halt_first();
      test_abort();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/boot_run_ctrl.md
# boot_run_ctrl

Boot and run sequencer for `single_cycle_cpu`. It accepts a program image as a valid/ready word stream and writes it into the instruction memory through a dedicated write port. It holds the core in reset during loading, releases it after a programmable delay, and counts execution cycles until the core signals halt or a cycle limit expires. It sits between the testbench/host loader and the CPU top, owning the core reset and the imem write port.

## Interface
- IMEM_DEPTH, 1024, imem entries (max program length in words)
- IMEM_ADDR_WIDTH, 10, imem word-address width
- RELEASE_DLY, 2, cycles core reset is held after the last load accept (legal range 1..15)
- CNT_WIDTH, 32, cycle counter width
- MAX_CYCLES, 100000, run-cycle limit; 0 = unlimited

- clk  in  1  system clock
- reset_b  in  1  asynchronous active-low reset
- start  in  1  pulse: begin load sequence (honoured in IDLE, DONE, ERR only)
- abort  in  1  pulse: return to IDLE from any state
- in_valid  in  1  stream word valid
- in_data  in  32  stream word (header, then instructions)
- in_ready  out  1  stream ready
- imem_we  out  1  imem write enable
- imem_waddr  out  IMEM_ADDR_WIDTH  imem word address
- imem_wdata  out  32  imem write data
- core_rst_b  out  1  active-low reset to CPU (pc and state)
- halt_req  in  1  CPU halt indication (level, sampled in RUN)
- busy  out  1  high in HDR, LOAD, RELEASE, RUN
- done  out  1  run finished (halt or timeout), sticky
- timeout  out  1  run ended by MAX_CYCLES, sticky
- error  out  1  bad header, sticky
- cycle_cnt  out  CNT_WIDTH  run cycles elapsed
- load_cnt  out  IMEM_ADDR_WIDTH+1  words written in the current/last load

## Operation
- States: IDLE, HDR, LOAD, RELEASE, RUN, DONE, ERR. Accept = in_valid & in_ready. in_ready = (state==HDR || state==LOAD), decoded from registered state.
- IDLE/DONE/ERR + start -> HDR. Clears done, timeout, error, load_cnt, cycle_cnt.
- HDR: on accept, N=in_data. If N==0 or N>IMEM_DEPTH -> ERR, error=1, no writes. Otherwise latch N, address=0 -> LOAD.
- LOAD: each accept registers imem_we=1, imem_waddr=address, imem_wdata=in_data; address++, load_cnt++. The accept of word N-1 -> RELEASE.
- RELEASE: down-counter loaded with RELEASE_DLY; core_rst_b stays 0; on expiry -> RUN.
- RUN: core_rst_b=1. cycle_cnt increments on every clock edge taken in RUN, including the exiting edge, and saturates at all-ones.
  - halt_req=1 -> DONE.
  - Otherwise, if MAX_CYCLES!=0 and cycle_cnt==MAX_CYCLES-1 -> DONE with timeout=1.
  - halt wins if both occur: timeout=0.
- DONE: done=1, core_rst_b=0, cycle_cnt holds.
- ERR: core_rst_b=0, error=1.
- abort has highest priority (over start, stream, halt): next state IDLE, core_rst_b=0, done/timeout/error cleared, counters hold. An imem write already registered completes; no further writes.
- start outside IDLE/DONE/ERR is ignored. A stream word presented while in_ready=0 is not consumed.

## Timing
- Reset values: state IDLE; in_ready 0, imem_we 0, imem_waddr 0, imem_wdata 0, core_rst_b 0, busy 0, done 0, timeout 0, error 0, cycle_cnt 0, load_cnt 0.
- All outputs are registered except in_ready, which is decoded from state.
- start at edge t -> HDR at t+1, in_ready=1 from t+1.
- Write latency: accept at edge t -> imem_we/waddr/wdata valid during cycle t+1 (single cycle, unless another accept follows).
- Last accept at edge t -> RELEASE at t+1 (last imem_we during this cycle) -> RUN and core_rst_b=1 at t+1+RELEASE_DLY.
- Back-to-back accepts sustain 1 word/cycle.
- Halt sampled at RUN edge k (cycle_cnt=k) -> DONE and done=1 at k+1, cycle_cnt=k+1, core_rst_b=0 in the same cycle.

## Test plan
- Load N=4 words 0x00500093,0x00100113,0x002081b3,0x00000013 with in_valid always high -> imem_we pulses on 4 consecutive cycles, addrs 0..3, load_cnt=4, core_rst_b rises exactly 2 cycles after the last write cycle.
- Random in_valid gaps (50%) with N=8 -> identical imem contents and addresses, no write in gap cycles, in_ready low outside HDR/LOAD.
- Header 0, then header 1025 (after a restart) -> ERR, error=1, imem_we never asserted, core_rst_b stays 0; start then a valid header loads normally.
- MAX_CYCLES=10, halt_req held 0 -> DONE with cycle_cnt=10, timeout=1, done=1, core_rst_b=0; halt_req asserted in the 10th RUN cycle -> timeout=0, cycle_cnt=10.
- halt_req=1 in first RUN cycle -> cycle_cnt=1, done=1.
- abort mid-LOAD (after 2 of 4 words), then abort mid-RUN -> next cycle IDLE, busy=0, in_ready=0, core_rst_b=0, no writes after the registered one; async reset_b asserted mid-RUN -> all outputs at reset values immediately.
